// File: rtl/csr_counter_wb.sv
`timescale 1ns/1ps
// csr_counter_wb: write-back-side owner of the mcycle/minstret performance
// counters and mcountinhibit. Applies the registered CSR write from the
// mem->wb stage, counts retire pulses, serves a combinational CSR read port
// and flags writes aimed at the read-only counter aliases.
module csr_counter_wb #(
    parameter int unsigned CNT_W   = 64,
    parameter logic [2:0]  INH_RST = 3'b000
) (
    input  logic        ck_i,
    input  logic        rs_i,
    input  logic        csr_we_i,
    input  logic [31:0] csr_wa_i,
    input  logic [31:0] csr_wd_i,
    input  logic        instret_incr_i,
    input  logic [11:0] rd_a_i,
    output logic [31:0] rd_d_o,
    output logic        rd_hit_o,
    output logic        wr_ro_err_o
);

    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MCOUNTINH = 12'h320;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    logic [11:0]      wa;
    logic             unused_wa_hi;
    logic             wr_cyc_lo;
    logic             wr_cyc_hi;
    logic             wr_ins_lo;
    logic             wr_ins_hi;
    logic             wr_inh;
    logic             wr_ro;
    logic [CNT_W-1:0] mcycle;
    logic [CNT_W-1:0] minstret;
    logic             cy_inh;
    logic             ir_inh;
    logic [63:0]      cyc64;
    logic [63:0]      ins64;

    assign wa           = csr_wa_i[11:0];
    assign unused_wa_hi = ^csr_wa_i[31:12];

    // Decode the registered write into one strobe per target.
    always_comb begin
        wr_cyc_lo = 1'b0;
        wr_cyc_hi = 1'b0;
        wr_ins_lo = 1'b0;
        wr_ins_hi = 1'b0;
        wr_inh    = 1'b0;
        wr_ro     = 1'b0;
        if (csr_we_i) begin
            case (wa)
                A_MCYCLE:    wr_cyc_lo = 1'b1;
                A_MCYCLEH:   wr_cyc_hi = 1'b1;
                A_MINSTRET:  wr_ins_lo = 1'b1;
                A_MINSTRETH: wr_ins_hi = 1'b1;
                A_MCOUNTINH: wr_inh    = 1'b1;
                A_CYCLE, A_CYCLEH, A_INSTRET, A_INSTRETH: wr_ro = 1'b1;
                default: ;
            endcase
        end
    end

    // Cycle counter: a write to either half replaces that half and suppresses counting.
    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i)
            mcycle <= '0;
        else if (wr_cyc_lo)
            mcycle[31:0] <= csr_wd_i;
        else if (wr_cyc_hi)
            mcycle[CNT_W-1:32] <= csr_wd_i[CNT_W-33:0];
        else if (!cy_inh)
            mcycle <= mcycle + CNT_W'(1);
    end

    // Retired-instruction counter: same write priority, counts on retire pulses.
    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i)
            minstret <= '0;
        else if (wr_ins_lo)
            minstret[31:0] <= csr_wd_i;
        else if (wr_ins_hi)
            minstret[CNT_W-1:32] <= csr_wd_i[CNT_W-33:0];
        else if (instret_incr_i && !ir_inh)
            minstret <= minstret + CNT_W'(1);
    end

    // Inhibit bits; only CY and IR are stored, TM is permanently zero.
    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i) begin
            cy_inh <= INH_RST[0];
            ir_inh <= INH_RST[2];
        end else if (wr_inh) begin
            cy_inh <= csr_wd_i[0];
            ir_inh <= csr_wd_i[2];
        end
    end

    // One-cycle error pulse for writes to the read-only aliases.
    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i)
            wr_ro_err_o <= 1'b0;
        else
            wr_ro_err_o <= wr_ro;
    end

    assign cyc64 = 64'(mcycle);
    assign ins64 = 64'(minstret);

    // Combinational read port from current state; no write forwarding.
    always_comb begin
        rd_d_o   = '0;
        rd_hit_o = 1'b0;
        case (rd_a_i)
            A_MCYCLE, A_CYCLE: begin
                rd_hit_o = 1'b1;
                rd_d_o   = cyc64[31:0];
            end
            A_MCYCLEH, A_CYCLEH: begin
                rd_hit_o = 1'b1;
                rd_d_o   = cyc64[63:32];
            end
            A_MINSTRET, A_INSTRET: begin
                rd_hit_o = 1'b1;
                rd_d_o   = ins64[31:0];
            end
            A_MINSTRETH, A_INSTRETH: begin
                rd_hit_o = 1'b1;
                rd_d_o   = ins64[63:32];
            end
            A_MCOUNTINH: begin
                rd_hit_o = 1'b1;
                rd_d_o   = {29'd0, ir_inh, 1'b0, cy_inh};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_counter_wb.sv
`timescale 1ns/1ps
// Bench for csr_counter_wb: two instances (64-bit, reset inhibit 0; 40-bit,
// reset inhibit 3'b111) share one stimulus stream and are checked against a
// 64-bit-with-mask model on every negedge across the whole address map.
module tb_csr_counter_wb;

    logic        ck = 1'b0;
    logic        rs = 1'b0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wa = '0;
    logic [31:0] csr_wd = '0;
    logic        instret_incr = 1'b0;
    logic [11:0] rd_a = '0;
    logic [31:0] rd_d0, rd_d1;
    logic        hit0, hit1, err0, err1;

    int asserts = 0;
    int fails   = 0;

    always #10 ck = ~ck;

    csr_counter_wb #(.CNT_W(64), .INH_RST(3'b000)) dut0 (
        .ck_i(ck), .rs_i(rs), .csr_we_i(csr_we), .csr_wa_i(csr_wa), .csr_wd_i(csr_wd),
        .instret_incr_i(instret_incr), .rd_a_i(rd_a), .rd_d_o(rd_d0), .rd_hit_o(hit0),
        .wr_ro_err_o(err0)
    );

    csr_counter_wb #(.CNT_W(40), .INH_RST(3'b111)) dut1 (
        .ck_i(ck), .rs_i(rs), .csr_we_i(csr_we), .csr_wa_i(csr_wa), .csr_wd_i(csr_wd),
        .instret_incr_i(instret_incr), .rd_a_i(rd_a), .rd_d_o(rd_d1), .rd_hit_o(hit1),
        .wr_ro_err_o(err1)
    );

    // ---------------- model ----------------
    logic [63:0] m_cyc [2];
    logic [63:0] m_ins [2];
    logic [2:0]  m_inh [2];
    logic        m_err [2];

    function automatic logic [63:0] wmask(input int d);
        return (d == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_00FF_FFFF_FFFF;
    endfunction

    always @(posedge ck or posedge rs) begin
        if (rs) begin
            m_cyc[0] <= 64'd0;  m_cyc[1] <= 64'd0;
            m_ins[0] <= 64'd0;  m_ins[1] <= 64'd0;
            m_inh[0] <= 3'b000; m_inh[1] <= 3'b101;
            m_err[0] <= 1'b0;   m_err[1] <= 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (csr_we && csr_wa[11:0] == 12'hB00)
                    m_cyc[d] <= {m_cyc[d][63:32], csr_wd};
                else if (csr_we && csr_wa[11:0] == 12'hB80)
                    m_cyc[d] <= {csr_wd, m_cyc[d][31:0]} & wmask(d);
                else if (!m_inh[d][0])
                    m_cyc[d] <= (m_cyc[d] + 64'd1) & wmask(d);

                if (csr_we && csr_wa[11:0] == 12'hB02)
                    m_ins[d] <= {m_ins[d][63:32], csr_wd};
                else if (csr_we && csr_wa[11:0] == 12'hB82)
                    m_ins[d] <= {csr_wd, m_ins[d][31:0]} & wmask(d);
                else if (instret_incr && !m_inh[d][2])
                    m_ins[d] <= (m_ins[d] + 64'd1) & wmask(d);

                if (csr_we && csr_wa[11:0] == 12'h320)
                    m_inh[d] <= csr_wd[2:0] & 3'b101;

                m_err[d] <= csr_we && (csr_wa[11:0] inside {12'hC00, 12'hC80, 12'hC02, 12'hC82});
            end
        end
    end

    function automatic logic [32:0] exp_rd(input int d, input logic [11:0] a);
        case (a)
            12'hB00, 12'hC00: return {1'b1, m_cyc[d][31:0]};
            12'hB80, 12'hC80: return {1'b1, m_cyc[d][63:32]};
            12'hB02, 12'hC02: return {1'b1, m_ins[d][31:0]};
            12'hB82, 12'hC82: return {1'b1, m_ins[d][63:32]};
            12'h320:          return {1'b1, 29'd0, m_inh[d]};
            default:          return 33'd0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    logic [11:0] sweep [13] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h320,
                                12'hC00, 12'hC80, 12'hC02, 12'hC82,
                                12'h000, 12'hB01, 12'h321, 12'hFFF};

    initial begin
        forever begin
            @(negedge ck);
            check("err0", 64'(err0), 64'(m_err[0]));
            check("err1", 64'(err1), 64'(m_err[1]));
            for (int i = 0; i < 13; i++) begin
                rd_a = sweep[i];
                #0.2;
                check($sformatf("rd0@%h", sweep[i]), 64'({hit0, rd_d0}), 64'(exp_rd(0, sweep[i])));
                check($sformatf("rd1@%h", sweep[i]), 64'({hit1, rd_d1}), 64'(exp_rd(1, sweep[i])));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic we, input logic [31:0] wa, input logic [31:0] wd, input logic inc);
        csr_we       = we;
        csr_wa       = wa;
        csr_wd       = wd;
        instret_incr = inc;
        @(posedge ck);
        #1;
        csr_we       = 1'b0;
        instret_incr = 1'b0;
    endtask

    initial begin
        #1 rs = 1'b1;
        repeat (2) @(posedge ck);
        #1 rs = 1'b0;

        // 1: ten clocks, four retire pulses
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 32'h0, 32'h0, (i == 1 || i == 3 || i == 4 || i == 8));
        check("t1_cyc0", m_cyc[0], 64'd10);
        check("t1_ins0", m_ins[0], 64'd4);
        check("t1_cyc1", m_cyc[1], 64'd0);
        check("t1_inh1", 64'(m_inh[1]), 64'd5);

        // 2: clear inhibit, preload low half all-ones, carry into high half
        cyc(1'b1, 32'h320, 32'h0, 1'b0);
        check("t2_inh1", 64'(m_inh[1]), 64'd0);
        check("t2_cyc0", m_cyc[0], 64'd11);
        cyc(1'b1, 32'hB00, 32'hFFFF_FFFF, 1'b0);
        cyc(1'b1, 32'hB80, 32'h0, 1'b0);
        check("t2_pre0", m_cyc[0], 64'h0000_0000_FFFF_FFFF);
        check("t2_pre1", m_cyc[1], 64'h0000_0000_FFFF_FFFF);
        cyc(1'b0, 32'h0, 32'h0, 1'b0);
        check("t2_carry0", m_cyc[0], 64'h0000_0001_0000_0000);
        check("t2_carry1", m_cyc[1], 64'h0000_0001_0000_0000);
        cyc(1'b0, 32'h0, 32'h0, 1'b0);
        check("t2_next0", m_cyc[0], 64'h0000_0001_0000_0001);

        // 3: write minstret while a retire pulse is present
        cyc(1'b1, 32'hB02, 32'd5, 1'b1);
        check("t3_ins0", m_ins[0], 64'd5);
        check("t3_ins1", m_ins[1], 64'd5);
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        check("t3_inc0", m_ins[0], 64'd6);

        // 4: inhibit both; write cycle still counts, then frozen
        cyc(1'b1, 32'h320, 32'h5, 1'b1);
        check("t4_cyc0", m_cyc[0], 64'h0000_0001_0000_0004);
        check("t4_ins0", m_ins[0], 64'd7);
        check("t4_inh0", 64'(m_inh[0]), 64'd5);
        repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b1);
        check("t4_frz_cyc0", m_cyc[0], 64'h0000_0001_0000_0004);
        check("t4_frz_ins0", m_ins[0], 64'd7);

        // 5: un-inhibit (old value applies in that cycle), then read-only alias writes
        cyc(1'b1, 32'h320, 32'h0, 1'b1);
        check("t5_still0", m_cyc[0], 64'h0000_0001_0000_0004);
        cyc(1'b1, 32'hC00, 32'h1234, 1'b1);
        check("t5_err0", 64'(m_err[0]), 64'd1);
        check("t5_cyc0", m_cyc[0], 64'h0000_0001_0000_0005);
        check("t5_ins0", m_ins[0], 64'd8);
        cyc(1'b0, 32'h0, 32'h0, 1'b0);
        check("t5_noerr0", 64'(m_err[0]), 64'd0);
        cyc(1'b1, 32'hC80, 32'h1, 1'b0);
        cyc(1'b1, 32'hC02, 32'h2, 1'b0);
        cyc(1'b1, 32'hC82, 32'h3, 1'b0);
        cyc(1'b1, 32'hB01, 32'h4, 1'b0);
        cyc(1'b1, 32'hABCD_EB02, 32'h77, 1'b0);
        check("t5_hiaddr0", m_ins[0], 64'h77);
        cyc(1'b1, 32'h320, 32'hFFFF_FFFF, 1'b0);
        check("t5_inhmask0", 64'(m_inh[0]), 64'd5);
        cyc(1'b1, 32'h320, 32'h0, 1'b0);

        // 6: all-ones preload; 40-bit instance wraps to zero
        cyc(1'b1, 32'hB00, 32'hFFFF_FFFF, 1'b0);
        cyc(1'b1, 32'hB80, 32'hFF, 1'b0);
        check("t6_pre1", m_cyc[1], 64'h0000_00FF_FFFF_FFFF);
        cyc(1'b0, 32'h0, 32'h0, 1'b0);
        check("t6_wrap1", m_cyc[1], 64'd0);
        check("t6_nowrap0", m_cyc[0], 64'h0000_0100_0000_0000);
        cyc(1'b1, 32'hB82, 32'hFFFF_FFFF, 1'b0);
        cyc(1'b1, 32'hB02, 32'hFFFF_FFFF, 1'b0);
        check("t6_ipre0", m_ins[0], 64'hFFFF_FFFF_FFFF_FFFF);
        check("t6_ipre1", m_ins[1], 64'h0000_00FF_FFFF_FFFF);
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        check("t6_iwrap0", m_ins[0], 64'd0);
        check("t6_iwrap1", m_ins[1], 64'd0);

        // reset mid-operation discards the pending write and increment
        csr_we = 1'b1; csr_wa = 32'hB00; csr_wd = 32'h55; instret_incr = 1'b1;
        #5 rs = 1'b1;
        @(posedge ck);
        #1 rs = 1'b0;
        csr_we = 1'b0; instret_incr = 1'b0;
        check("rst_cyc0", m_cyc[0], 64'd0);
        check("rst_ins0", m_ins[0], 64'd0);
        check("rst_inh1", 64'(m_inh[1]), 64'd5);
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        check("rst_run0", m_cyc[0], 64'd1);
        check("rst_frz1", m_cyc[1], 64'd0);

        @(negedge ck);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $fatal(1);
    end

endmodule
